// File: rtl/dpsram_arb_if.sv
// Requester-side handshake bundle for dpsram_arb.
// Packed per-requester fields, slot i at [i*W +: W].
interface dpsram_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_we;
  logic [NUM_REQ*S_INDEX-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ*WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dpsram_arb.sv
// Round-robin arbiter sharing one two-port SRAM among NUM_REQ requesters,
// with same-cycle write-to-read forwarding.
module dpsram_arb #(
  parameter int NUM_REQ = 3,
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  dpsram_arb_if.slave        bus,
  output logic               csb0,
  output logic               web0,
  output logic [S_INDEX-1:0] addr0,
  output logic [WIDTH-1:0]   din0,
  input  logic [WIDTH-1:0]   dout0,
  output logic               csb1,
  output logic               web1,
  output logic [S_INDEX-1:0] addr1,
  output logic [WIDTH-1:0]   din1,
  input  logic [WIDTH-1:0]   dout1
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_nxt;
  logic [PW-1:0]      i0;
  logic [PW-1:0]      i1;
  logic [PW-1:0]      last;
  logic [PW-1:0]      idx;
  logic [PW:0]        sum;
  logic               g0;
  logic               g1;

  logic [S_INDEX-1:0] a [NUM_REQ];
  logic [WIDTH-1:0]   d [NUM_REQ];
  logic [NUM_REQ-1:0] we;

  logic [NUM_REQ-1:0] rg;
  logic [NUM_REQ-1:0] sel_n;
  logic [NUM_REQ-1:0] fwd_n;
  logic [WIDTH-1:0]   fd_n [NUM_REQ];

  logic [NUM_REQ-1:0] vq;
  logic [NUM_REQ-1:0] sel;
  logic [NUM_REQ-1:0] fwd;
  logic [WIDTH-1:0]   fwd_data [NUM_REQ];

  assign we = bus.req_we;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a[i] = bus.req_addr[i*S_INDEX +: S_INDEX];
      d[i] = bus.req_wdata[i*WIDTH +: WIDTH];
    end
  end

  // Scan from ptr; port 1 skips a write colliding with port 0's write.
  always_comb begin
    g0  = 1'b0;
    g1  = 1'b0;
    i0  = '0;
    i1  = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!rst && bus.req_valid[idx]) begin
        if (!g0) begin
          g0 = 1'b1;
          i0 = idx;
        end else if (!g1 &&
                     !(we[idx] && we[i0] && a[idx] == a[i0])) begin
          g1 = 1'b1;
          i1 = idx;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (g0) bus.req_ready[i0] = 1'b1;
    if (g1) bus.req_ready[i1] = 1'b1;
  end

  assign last = g1 ? i1 : i0;

  always_comb begin
    ptr_nxt = ptr;
    if (g0)
      ptr_nxt = (last == PW'(NUM_REQ-1)) ? '0 : last + 1'b1;
  end

  assign csb0  = !g0;
  assign web0  = g0 ? !we[i0] : 1'b1;
  assign addr0 = g0 ? a[i0] : '0;
  assign din0  = g0 ? d[i0] : '0;
  assign csb1  = !g1;
  assign web1  = g1 ? !we[i1] : 1'b1;
  assign addr1 = g1 ? a[i1] : '0;
  assign din1  = g1 ? d[i1] : '0;

  // Per-slot response bookkeeping for reads granted this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rg[i]    = 1'b0;
      sel_n[i] = 1'b0;
      fwd_n[i] = 1'b0;
      fd_n[i]  = '0;
      if (g0 && i0 == PW'(i) && !we[i]) begin
        rg[i]    = 1'b1;
        fwd_n[i] = g1 && we[i1] && a[i1] == a[i];
        fd_n[i]  = fwd_n[i] ? d[i1] : '0;
      end else if (g1 && i1 == PW'(i) && !we[i]) begin
        rg[i]    = 1'b1;
        sel_n[i] = 1'b1;
        fwd_n[i] = we[i0] && a[i0] == a[i];
        fd_n[i]  = fwd_n[i] ? d[i0] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      vq  <= '0;
      sel <= '0;
      fwd <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        fwd_data[i] <= '0;
    end else begin
      ptr <= ptr_nxt;
      vq  <= rg;
      sel <= sel_n;
      fwd <= fwd_n;
      for (int i = 0; i < NUM_REQ; i++)
        fwd_data[i] <= fd_n[i];
    end
  end

  // A read granted just before reset must not surface while rst is high.
  assign bus.rsp_valid = vq & {NUM_REQ{!rst}};

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!bus.rsp_valid[i])
        bus.rsp_rdata[i*WIDTH +: WIDTH] = '0;
      else if (fwd[i])
        bus.rsp_rdata[i*WIDTH +: WIDTH] = fwd_data[i];
      else
        bus.rsp_rdata[i*WIDTH +: WIDTH] = sel[i] ? dout1 : dout0;
    end
  end
endmodule

// File: tb/tb_dpsram_arb.sv
// Directed bench for dpsram_arb with a behavioural two-port SRAM.
// Inputs change 1ns after posedge; checks follow a further 1ns settle.
module tb_dpsram_arb;
  logic clk = 1'b0;
  logic rst;
  logic csb0, web0, csb1, web1;
  logic [3:0]  addr0, addr1;
  logic [31:0] din0, din1, dout0, dout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dpsram_arb_if #(.NUM_REQ(3), .S_INDEX(4), .WIDTH(32)) bus ();

  dpsram_arb #(.NUM_REQ(3), .S_INDEX(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .dout0(dout0),
    .csb1(csb1), .web1(web1), .addr1(addr1),
    .din1(din1), .dout1(dout1)
  );

  // SRAM model: latch at edge, commit write next edge, read array live.
  logic [31:0] mem [16];
  logic        l_csb [2];
  logic        l_web [2];
  logic [3:0]  l_adr [2];
  logic [31:0] l_din [2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      for (int p = 0; p < 2; p++) begin
        l_csb[p] <= 1'b1;
        l_web[p] <= 1'b1;
        l_adr[p] <= '0;
        l_din[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++)
        if (!l_csb[p] && !l_web[p]) mem[l_adr[p]] <= l_din[p];
      l_csb[0] <= csb0; l_web[0] <= web0;
      l_adr[0] <= addr0; l_din[0] <= din0;
      l_csb[1] <= csb1; l_web[1] <= web1;
      l_adr[1] <= addr1; l_din[1] <= din1;
    end
  end

  assign dout0 = (!l_csb[0] && l_web[0]) ? mem[l_adr[0]] : '0;
  assign dout1 = (!l_csb[1] && l_web[1]) ? mem[l_adr[1]] : '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [3:0] a, input logic [31:0] dt);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = w;
    bus.req_addr[i*4 +: 4]    = a;
    bus.req_wdata[i*32 +: 32] = dt;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdata(input int i);
    logic [95:0] v;
    v = bus.rsp_rdata;
    return v[i*32 +: 32];
  endfunction

  logic [2:0] exp_rdy [3];
  logic [2:0] prev;
  int cnt [3];

  initial begin
    exp_rdy[0] = 3'b011;
    exp_rdy[1] = 3'b101;
    exp_rdy[2] = 3'b110;
    for (int i = 0; i < 3; i++) cnt[i] = 0;

    // Reset with all requesters reading addresses 0,1,2.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 4'(i), 32'h0);
    #1;
    for (int c = 0; c < 2; c++) begin
      check("rst_ready", 64'(bus.req_ready), 64'h0);
      check("rst_csb", 64'({csb0, csb1}), 64'h3);
      check("rst_web", 64'({web0, web1}), 64'h3);
      check("rst_rspv", 64'(bus.rsp_valid), 64'h0);
      tick();
    end

    // Fairness: continuous reads from all three.
    rst = 1'b0;
    #1;
    check("first_addr0", 64'(addr0), 64'h0);
    prev = 3'b000;
    for (int c = 0; c < 6; c++) begin
      check("rr_ready", 64'(bus.req_ready), 64'(exp_rdy[c % 3]));
      check("rr_rspv", 64'(bus.rsp_valid), 64'(prev));
      prev = exp_rdy[c % 3];
      for (int i = 0; i < 3; i++) cnt[i] += int'(bus.req_ready[i]);
      tick();
      #1;
    end
    check("rr_rspv_last", 64'(bus.rsp_valid), 64'(prev));
    for (int i = 0; i < 3; i++) check("rr_count", 64'(cnt[i]), 64'd4);

    // Write then read on the next cycle, no forwarding needed.
    clear_all();
    set_req(0, 1'b1, 1'b1, 4'h5, 32'hDEADBEEF);
    #1;
    check("wr5_ready", 64'(bus.req_ready), 64'h1);
    tick();
    clear_all();
    set_req(1, 1'b1, 1'b0, 4'h5, 32'h0);
    #1;
    check("rd5_ready", 64'(bus.req_ready), 64'h2);
    tick();
    check("rd5_rspv", 64'(bus.rsp_valid), 64'h2);
    check("rd5_data", 64'(rdata(1)), 64'hDEADBEEF);

    // Same-cycle read/write collision is forwarded.
    clear_all();
    set_req(0, 1'b1, 1'b1, 4'h3, 32'h11);
    #1;
    tick();
    clear_all();
    set_req(0, 1'b1, 1'b0, 4'h3, 32'h0);
    set_req(1, 1'b1, 1'b1, 4'h3, 32'h22);
    #1;
    check("fwd_ready", 64'(bus.req_ready), 64'h3);
    check("fwd_csb", 64'({csb0, csb1}), 64'h0);
    tick();
    clear_all();
    check("fwd_rspv", 64'(bus.rsp_valid), 64'h1);
    check("fwd_data", 64'(rdata(0)), 64'h22);
    set_req(2, 1'b1, 1'b0, 4'h3, 32'h0);
    #1;
    check("rd3_ready", 64'(bus.req_ready), 64'h4);
    tick();
    check("rd3_data", 64'(rdata(2)), 64'h22);

    // Read granted, then reset: the response is dropped.
    clear_all();
    set_req(0, 1'b1, 1'b0, 4'h3, 32'h0);
    #1;
    check("prerst_ready", 64'(bus.req_ready), 64'h1);
    tick();
    rst = 1'b1;
    clear_all();
    #1;
    check("midrst_rspv", 64'(bus.rsp_valid), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("postrst_rspv", 64'(bus.rsp_valid), 64'h0);

    // Write-write conflict right after reset (ptr back at 0).
    set_req(0, 1'b1, 1'b1, 4'h7, 32'hA);
    set_req(1, 1'b1, 1'b1, 4'h7, 32'hB);
    #1;
    check("ww_ready0", 64'(bus.req_ready), 64'h1);
    check("ww_csb1", 64'(csb1), 64'h1);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    #1;
    check("ww_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    clear_all();
    set_req(0, 1'b1, 1'b0, 4'h3, 32'h0);
    set_req(2, 1'b1, 1'b0, 4'h7, 32'h0);
    #1;
    check("ww_rd_ready", 64'(bus.req_ready), 64'h5);
    tick();
    check("ww_rspv", 64'(bus.rsp_valid), 64'h5);
    check("ww_rd7", 64'(rdata(2)), 64'hB);
    check("rst_rd3", 64'(rdata(0)), 64'h0);
    clear_all();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dpsram_arb.md
# dpsram_arb

Round-robin arbiter and sequencer that shares one two-port `dpsram` instance among `NUM_REQ` requesters. Each cycle it grants up to two compatible requests, one per SRAM port. It returns read data one cycle after grant. It forwards same-cycle write data to a colliding read, which the SRAM does not do internally. It sits between core structures (ROB/RAT/free-list users) and the storage array.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8)
- `S_INDEX`, 4, SRAM address width
- `WIDTH`, 32, data width

Ports:
- `clk`  in  1  clock; also drives the SRAM `clk0`
- `rst`  in  1  synchronous, active-high reset; also drives the SRAM `rst0`
- `req_valid`  in  NUM_REQ  request present, one bit per requester
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*S_INDEX  address; requester i occupies bits [i*S_INDEX +: S_INDEX]
- `req_wdata`  in  NUM_REQ*WIDTH  write data, packed the same way
- `req_ready`  out  NUM_REQ  combinational grant; a transfer occurs when valid && ready
- `rsp_valid`  out  NUM_REQ  read data valid, one per requester
- `rsp_rdata`  out  NUM_REQ*WIDTH  read data, packed the same way
- `csb0`, `web0`  out  1 each  SRAM port 0 chip select and write enable (active-low)
- `addr0`  out  S_INDEX  SRAM port 0 address
- `din0`  out  WIDTH  SRAM port 0 write data
- `dout0`  in  WIDTH  SRAM port 0 read data
- `csb1`, `web1`, `addr1`, `din1`, `dout1`: same as port 0, for port 1

## Operation
- **Round-robin pointer.** `ptr` has width clog2(NUM_REQ) and resets to 0.
- **Scan.** Each cycle, scan the requesters in order ptr, ptr+1, … (mod NUM_REQ).
  - The first valid requester gets port 0.
  - The next valid, compatible requester gets port 1.
- **Compatibility.** Two writes to the same address are incompatible. The later one in scan order is skipped (ready=0) and the scan continues. A read and a write to the same address are compatible.
- **Port drive.** A granted port drives csb=0, web=!req_we, addr, din. An idle port drives csb=1, web=1, addr=0, din=0.
- **Pointer update.** If any grant occurs, ptr ← (index of the last granted requester + 1) mod NUM_REQ. Otherwise ptr holds.
- **Response registers.** For each granted read, register:
  - `rsp_valid[i]` = 1;
  - `sel[i]` = which port served it;
  - `fwd[i]`/`fwd_data[i]`: set when the other port was granted a write to the same address in the same cycle.
- **Response data.**
  - `rsp_rdata[i]` = fwd[i] ? fwd_data[i] : (sel[i] ? dout1 : dout0).
  - This is combinational in the response cycle.
  - A slot that is not valid outputs 0.
- **Write completion.** Writes produce no response.
- **No flow control on responses.** Requesters must accept `rsp_valid` unconditionally.

## Timing
- **Grant.** Grant is combinational in cycle t.
- **SRAM latch.** The SRAM registers the request at edge t+1.
- **Read data.** Read data is valid during cycle t+1 (latency 1). `rsp_valid` is high for exactly one cycle.
- **Write commit.** A write granted at t commits to the array at edge t+2.
- **Write then read, next cycle.** A read of the same address granted at t+1 sees the new data in cycle t+2. The arbiter requires no bypass for this case.
- **Same-cycle read/write collision.** A read and a write to the same address granted in the same cycle t would get old data from the SRAM at t+1. The arbiter must return the write data via `fwd` instead.
- **Back-to-back grants.** The same requester may be granted on consecutive cycles. There is no bubble.
- **During `rst`.**
  - `req_ready` = 0.
  - Both ports idle (csb=1, web=1).
  - `ptr` ← 0.
  - All `rsp_valid`, `sel`, `fwd` and `fwd_data` ← 0.
- **After `rst`.**
  - A read granted in the last cycle before `rst` asserts produces no response.
  - The first grant is possible in the first cycle after `rst` deasserts.
- **Port limit.** At most 2 grants per cycle. Any other valid requesters see ready=0 and must hold their request stable.

## Test plan
1. **Reset.** Assert `rst` 2 cycles with all requesters valid → req_ready=0, csb0=csb1=1, rsp_valid=0. The first post-reset grant goes to requester 0.
2. **Write then read.** Req0 writes addr 5 = 0xDEADBEEF at t; req1 reads addr 5 at t+1 → rsp_valid[1] at t+2 with rsp_rdata[1]=0xDEADBEEF.
3. **Same-cycle forward.** Req0 reads addr 3 (holding 0x11) while req1 writes addr 3 = 0x22, same cycle → rsp_rdata[0]=0x22 next cycle. A later read of addr 3 also returns 0x22.
4. **Write-write conflict.** Req0 and req1 both write addr 7 (0xA, then 0xB) while req2 is idle, ptr=0 → only req0 granted in the first cycle; req1 is granted next cycle. A final read of addr 7 returns 0xB.
5. **Fairness.** All 3 requesters issue continuous reads → grant pairs cycle through {0,1}, {2,0}, {1,2}, … Each requester receives exactly 2 grants per 3 cycles.
6. **Reset mid-operation.** Assert `rst` the cycle after a read grant → no rsp_valid in the following cycle. The array reads 0 afterwards and ptr restarts at 0.
